// File: rtl/frame_sequencer.sv
// frame_sequencer: per-frame controller for the senone-scoring datapath.
//
// Sequence per frame: wait for a feature vector, kick the GDP controller,
// buffer every senone score, normalise the buffer against the frame maximum,
// then stream the normalised scores to the data UART one number at a time.
//
// Ports
//   clk, reset            system clock, asynchronous active-high reset
//   rx_available          pulse: new feature vector in the UART rx buffer
//   gdp_idle              GDP controller idle
//   score_ready           pulse: senone_idx / senone_score valid
//   senone_idx            index of the current score
//   senone_score          signed score
//   last_senone           qualifies score_ready: final senone of the frame
//   best_score            running maximum from the max unit
//   tx_busy               UART transmitting (rises the cycle after start_tx)
//   new_vector_available  pulse: start the GDP controller
//   max_clear             pulse: reset the max unit
//   start_tx / tx_num     pulse + number to transmit
//   state_o               0=IDLE 1=PROC 2=NORM 3=SEND
//   frame_done            pulse after the last number of a frame is sent
//   overrun               sticky: rx_available seen while busy or GDP not idle
//   idx_err               sticky: bad senone index or score count mismatch
//   timeout_err           sticky: PROC watchdog expired (SEQ_TIMEOUT_EN only)
//
// Build option: define SEQ_TIMEOUT_EN to add the PROC watchdog and timeout_err.

module frame_sequencer #(
    parameter int unsigned N_SENONES      = 10,
    parameter int unsigned SCORE_W        = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rx_available,
    input  logic                      gdp_idle,
    input  logic                      score_ready,
    input  logic [7:0]                senone_idx,
    input  logic signed [SCORE_W-1:0] senone_score,
    input  logic                      last_senone,
    input  logic signed [SCORE_W-1:0] best_score,
    input  logic                      tx_busy,
    output logic                      new_vector_available,
    output logic                      max_clear,
    output logic                      start_tx,
    output logic signed [SCORE_W-1:0] tx_num,
    output logic [1:0]                state_o,
    output logic                      frame_done,
    output logic                      overrun,
    output logic                      idx_err
`ifdef SEQ_TIMEOUT_EN
    ,
    output logic                      timeout_err
`endif
);

    if (N_SENONES < 2 || N_SENONES > 255 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("frame_sequencer: parameter out of range");
    end

    localparam int unsigned IDX_W  = $clog2(N_SENONES);
    localparam logic [8:0]  N_CNT  = 9'(N_SENONES);
    localparam logic [8:0]  N_LAST = 9'(N_SENONES - 1);

    localparam logic signed [SCORE_W-1:0] SAT_MAX = {1'b0, {(SCORE_W-1){1'b1}}};
    localparam logic signed [SCORE_W-1:0] SAT_MIN = {1'b1, {(SCORE_W-1){1'b0}}};

    typedef enum logic [2:0] {
        StIdle,
        StProc,
        StNorm,
        StSendIssue,
        StSendWaitHi,
        StSendWaitLo
    } state_e;

    state_e state_q, state_d;

    logic [8:0]                count_q;  // valid scores written this frame
    logic [8:0]                pos_q;    // NORM step (0 = latch bref) or SEND index
    logic signed [SCORE_W-1:0] bref_q;
    logic signed [SCORE_W-1:0] score_buf [N_SENONES];

    logic nva_d, max_clear_d, start_tx_d, frame_done_d;
    logic idx_ok, score_hit, frame_end, send_last, timeout_hit;

    logic [IDX_W-1:0]          wr_idx;
    logic [IDX_W-1:0]          norm_idx;
    logic [IDX_W-1:0]          send_idx;
    logic signed [SCORE_W:0]   diff;
    logic signed [SCORE_W-1:0] norm_val;

    assign idx_ok    = ({1'b0, senone_idx} < N_CNT);
    assign score_hit = (state_q == StProc) && score_ready;
    assign frame_end = score_hit && last_senone;
    assign send_last = (pos_q == N_LAST);

    assign wr_idx   = senone_idx[IDX_W-1:0];
    assign norm_idx = IDX_W'(pos_q - 9'd1);
    assign send_idx = IDX_W'(pos_q);

    // One extra bit so the difference never wraps before saturation.
    always_comb begin
        diff     = {score_buf[norm_idx][SCORE_W-1], score_buf[norm_idx]}
                 - {bref_q[SCORE_W-1], bref_q};
        norm_val = diff[SCORE_W-1:0];
        if (diff[SCORE_W] != diff[SCORE_W-1]) begin
            norm_val = diff[SCORE_W] ? SAT_MIN : SAT_MAX;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    localparam int unsigned     TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt_q;

    // Fires on the TIMEOUT_CYCLES-th consecutive PROC cycle without a score.
    assign timeout_hit = (state_q == StProc) && !score_ready && (to_cnt_q == TO_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_q    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state_q != StProc || score_ready) begin
                to_cnt_q <= '0;
            end else begin
                to_cnt_q <= to_cnt_q + TO_W'(1);
            end
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (rx_available && gdp_idle) state_d = StProc;
            end
            StProc: begin
                if (frame_end) begin
                    state_d = StNorm;
                end else if (timeout_hit) begin
                    state_d = StIdle;
                end
            end
            StNorm: begin
                if (pos_q == N_CNT) state_d = StSendIssue;
            end
            StSendIssue: begin
                if (!tx_busy) state_d = StSendWaitHi;
            end
            StSendWaitHi: begin
                if (tx_busy) state_d = StSendWaitLo;
            end
            StSendWaitLo: begin
                if (!tx_busy) state_d = send_last ? StIdle : StSendIssue;
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic: next values of the registered pulses, and the state code
    always_comb begin
        nva_d        = (state_q == StIdle) && rx_available && gdp_idle;
        max_clear_d  = nva_d || timeout_hit;
        start_tx_d   = (state_q == StSendIssue) && !tx_busy;
        frame_done_d = (state_q == StSendWaitLo) && !tx_busy && send_last;
        state_o      = 2'd0;
        unique case (state_q)
            StIdle:                                  state_o = 2'd0;
            StProc:                                  state_o = 2'd1;
            StNorm:                                  state_o = 2'd2;
            StSendIssue, StSendWaitHi, StSendWaitLo: state_o = 2'd3;
            default:                                 state_o = 2'd0;
        endcase
    end

    // Control registers and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q              <= '0;
            pos_q                <= '0;
            bref_q               <= '0;
            tx_num               <= '0;
            new_vector_available <= 1'b0;
            max_clear            <= 1'b0;
            start_tx             <= 1'b0;
            frame_done           <= 1'b0;
            overrun              <= 1'b0;
            idx_err              <= 1'b0;
        end else begin
            new_vector_available <= nva_d;
            max_clear            <= max_clear_d;
            start_tx             <= start_tx_d;
            frame_done           <= frame_done_d;

            if (rx_available && (state_q != StIdle || !gdp_idle)) begin
                overrun <= 1'b1;
            end

            if (nva_d) begin
                count_q <= '0;
            end else if (score_hit && idx_ok) begin
                count_q <= count_q + 9'd1;
            end

            if (score_hit && !idx_ok) begin
                idx_err <= 1'b1;
            end
            // count_q has not yet absorbed the current score
            if (frame_end && (count_q + 9'd1 != N_CNT)) begin
                idx_err <= 1'b1;
            end

            if (frame_end) begin
                pos_q <= '0;
            end else if (state_q == StNorm) begin
                pos_q <= (pos_q == N_CNT) ? 9'd0 : pos_q + 9'd1;
            end else if (state_q == StSendWaitLo && !tx_busy && !send_last) begin
                pos_q <= pos_q + 9'd1;
            end

            // The max unit has registered the final score by NORM cycle 0.
            if (state_q == StNorm && pos_q == 9'd0) begin
                bref_q <= best_score;
            end

            if (start_tx_d) begin
                tx_num <= score_buf[send_idx];
            end
        end
    end

    // Score buffer: contents are don't-care after reset, so it has no reset.
    always_ff @(posedge clk) begin
        if (score_hit && idx_ok) begin
            score_buf[wr_idx] <= senone_score;
        end else if (state_q == StNorm && pos_q != 9'd0) begin
            score_buf[norm_idx] <= norm_val;
        end
    end

endmodule

// File: tb/tb_frame_sequencer.sv
module tb_frame_sequencer;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int TO = 50;

    logic                clk = 1'b0;
    logic                reset;
    logic                rx_available;
    logic                gdp_idle;
    logic                score_ready;
    logic [7:0]          senone_idx;
    logic signed [W-1:0] senone_score;
    logic                last_senone;
    logic signed [W-1:0] best_score;
    logic                tx_busy;
    logic                new_vector_available;
    logic                max_clear;
    logic                start_tx;
    logic signed [W-1:0] tx_num;
    logic [1:0]          state_o;
    logic                frame_done;
    logic                overrun;
    logic                idx_err;
`ifdef SEQ_TIMEOUT_EN
    logic                timeout_err;
`endif

    frame_sequencer #(
        .N_SENONES      (N),
        .SCORE_W        (W),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .rx_available         (rx_available),
        .gdp_idle             (gdp_idle),
        .score_ready          (score_ready),
        .senone_idx           (senone_idx),
        .senone_score         (senone_score),
        .last_senone          (last_senone),
        .best_score           (best_score),
        .tx_busy              (tx_busy),
        .new_vector_available (new_vector_available),
        .max_clear            (max_clear),
        .start_tx             (start_tx),
        .tx_num               (tx_num),
        .state_o              (state_o),
        .frame_done           (frame_done),
        .overrun              (overrun),
        .idx_err              (idx_err)
`ifdef SEQ_TIMEOUT_EN
        ,
        .timeout_err          (timeout_err)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int mon_exp;
    int gap;
    int n_wait;
    bit stall_next = 1'b0;

    int exp_q[$];      // scoreboard: expected tx_num values in send order
    int st_times[$];   // cycle stamps of observed start_tx pulses

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: compare every transmitted number against the scoreboard.
    initial forever begin
        @(negedge clk);
        if (start_tx === 1'b1) begin
            st_times.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("start_tx unexpected", int'(start_tx), 0);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("tx_num", int'(tx_num), mon_exp);
            end
        end
    end

    // UART model: busy from the cycle after start_tx for 3 (or 500) cycles.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (start_tx === 1'b1) begin
                @(posedge clk);
                #1 tx_busy = 1'b1;
                repeat (stall_next ? 500 : 3) @(posedge clk);
                stall_next = 1'b0;
                #1 tx_busy = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        rx_available = 1'b1;
        tick();
        rx_available = 1'b0;
        chk("nva pulse", int'(new_vector_available), 1);
        chk("max_clear pulse", int'(max_clear), 1);
        chk("state PROC", int'(state_o), 1);
        tick();
        chk("nva single", int'(new_vector_available), 0);
        chk("max_clear single", int'(max_clear), 0);
    endtask

    task automatic send(input int idx, input int score, input bit last);
        senone_idx   = 8'(idx);
        senone_score = W'(score);
        last_senone  = last;
        score_ready  = 1'b1;
        tick();
        score_ready  = 1'b0;
        last_senone  = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (frame_done !== 1'b1 && n < 3000) begin
            tick();
            n++;
        end
        chk({name, " frame_done"}, int'(frame_done), 1);
        chk({name, " state idle"}, int'(state_o), 0);
        chk({name, " all sent"}, exp_q.size(), 0);
        tick();
        chk({name, " frame_done single"}, int'(frame_done), 0);
    endtask

    initial begin
        reset        = 1'b1;
        rx_available = 1'b0;
        gdp_idle     = 1'b1;
        score_ready  = 1'b0;
        senone_idx   = '0;
        senone_score = '0;
        last_senone  = 1'b0;
        best_score   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst state", int'(state_o), 0);
        chk("rst nva", int'(new_vector_available), 0);
        chk("rst max_clear", int'(max_clear), 0);
        chk("rst start_tx", int'(start_tx), 0);
        chk("rst tx_num", int'(tx_num), 0);
        chk("rst frame_done", int'(frame_done), 0);
        chk("rst overrun", int'(overrun), 0);
        chk("rst idx_err", int'(idx_err), 0);
        reset = 1'b0;
        tick();

        // Normal frame
        exp_q = '{-7, 0, -4, -17};
        start_frame();
        send(0, -10, 0);
        send(1, -3, 0);
        send(2, -7, 0);
        best_score = -3;
        send(3, -20, 1);
        wait_done("normal");

        // Negative saturation; other entries exact
        exp_q = '{-32768, -500, 0, -1005};
        start_frame();
        send(0, -32000, 0);
        send(1, 500, 0);
        send(2, 1000, 0);
        best_score = 1000;
        send(3, -5, 1);
        wait_done("neg sat");

        // Out-of-order indices, positive saturation
        exp_q = '{999, 1007, 1100, 32767};
        start_frame();
        send(3, 32000, 0);
        send(1, 7, 0);
        send(0, -1, 0);
        best_score = -1000;
        send(2, 100, 1);
        wait_done("out of order");
        chk("no idx_err", int'(idx_err), 0);
        chk("no overrun", int'(overrun), 0);

        // Overrun during SEND and a 500-cycle tx_busy stall
        exp_q = '{-3, -2, -1, 0};
        st_times.delete();
        stall_next = 1'b1;
        start_frame();
        send(0, 1, 0);
        send(1, 2, 0);
        send(2, 3, 0);
        best_score = 4;
        send(3, 4, 1);
        n_wait = 0;
        while (state_o != 2'd3 && n_wait < 100) begin
            tick();
            n_wait++;
        end
        chk("reach SEND", int'(state_o), 3);
        rx_available = 1'b1;
        tick();
        rx_available = 1'b0;
        chk("overrun set", int'(overrun), 1);
        chk("stay SEND", int'(state_o), 3);
        chk("no nva in SEND", int'(new_vector_available), 0);
        wait_done("overrun");
        chk("stall start count", st_times.size(), 4);
        gap = (st_times.size() >= 2) ? st_times[1] - st_times[0] : 0;
        chk("stall gap >= 500", int'(gap >= 500), 1);

        // Bad index: flagged, no write (would alias onto index 3)
        exp_q = '{-3, -2, -1, 0};
        start_frame();
        send(3, 8, 0);
        send(7, 1234, 0);
        chk("idx_err set", int'(idx_err), 1);
        send(0, 5, 0);
        send(1, 6, 0);
        best_score = 8;
        send(2, 7, 1);
        wait_done("bad idx");

        // Reset in NORM
        start_frame();
        send(0, 1, 0);
        send(1, 2, 0);
        send(2, 3, 0);
        best_score = 4;
        send(3, 4, 1);
        tick();
        tick();
        chk("in NORM", int'(state_o), 2);
        reset = 1'b1;
        #1;
        chk("mid rst state", int'(state_o), 0);
        chk("mid rst nva", int'(new_vector_available), 0);
        chk("mid rst max_clear", int'(max_clear), 0);
        chk("mid rst start_tx", int'(start_tx), 0);
        chk("mid rst tx_num", int'(tx_num), 0);
        chk("mid rst frame_done", int'(frame_done), 0);
        chk("mid rst overrun", int'(overrun), 0);
        chk("mid rst idx_err", int'(idx_err), 0);
        tick();
        tick();
        reset = 1'b0;
        repeat (30) tick();
        chk("idle after abort", int'(state_o), 0);

        // Full frame after reset
        exp_q = '{-7, 0, -4, -17};
        start_frame();
        send(0, -10, 0);
        send(1, -3, 0);
        send(2, -7, 0);
        best_score = -3;
        send(3, -20, 1);
        wait_done("after reset");
        chk("clean idx_err", int'(idx_err), 0);

        // Count mismatch: 3 scores; entry 3 still holds -17 from last frame
        exp_q = '{-20, -10, 0, -47};
        start_frame();
        send(0, 10, 0);
        send(1, 20, 0);
        best_score = 30;
        send(2, 30, 1);
        chk("count mismatch idx_err", int'(idx_err), 1);
        wait_done("mismatch");
        chk("overrun still clear", int'(overrun), 0);

        // rx_available while GDP busy
        gdp_idle     = 1'b0;
        rx_available = 1'b1;
        tick();
        rx_available = 1'b0;
        gdp_idle     = 1'b1;
        chk("gdp busy stays IDLE", int'(state_o), 0);
        chk("gdp busy no nva", int'(new_vector_available), 0);
        chk("gdp busy overrun", int'(overrun), 1);

`ifdef SEQ_TIMEOUT_EN
        start_frame();
        send(0, 1, 0);
        send(1, 2, 0);
        repeat (TO - 1) tick();
        chk("timeout not early", int'(timeout_err), 0);
        chk("still PROC", int'(state_o), 1);
        tick();
        chk("timeout_err", int'(timeout_err), 1);
        chk("timeout max_clear", int'(max_clear), 1);
        chk("timeout state", int'(state_o), 0);
        tick();
        chk("timeout max_clear single", int'(max_clear), 0);
        repeat (10) tick();
        chk("timeout no tx", exp_q.size(), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Per-frame controller for the senone-scoring datapath. Runs GDP scoring, then max tracking, then normalisation, then UART transmit.
- Waits for a received feature vector and triggers the GDP controller.
- Buffers each senone score and takes the frame maximum from the max unit.
- Normalises every buffered score against that maximum, then streams the results one number at a time to the data UART.
- Exports its state for the status LED.

Parameters:
- N_SENONES, 10, senones per frame and score buffer depth (2..255).
- SCORE_W, 16, signed score width.
- TIMEOUT_CYCLES, 1000000, PROC watchdog limit. Used only with SEQ_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rx_available  in  1  one-cycle pulse: a new feature vector is in the UART rx buffer.
- gdp_idle  in  1  GDP controller idle.
- score_ready  in  1  one-cycle pulse: senone_idx/senone_score valid.
- senone_idx  in  8  senone index of the current score.
- senone_score  in  SCORE_W  signed score.
- last_senone  in  1  qualifies score_ready: this is the final senone of the frame.
- best_score  in  SCORE_W  signed running maximum from the max unit.
- tx_busy  in  1  UART transmitting. Rises the cycle after start_tx.
- new_vector_available  out  1  one-cycle pulse that starts the GDP controller.
- max_clear  out  1  one-cycle pulse that resets the max unit.
- start_tx  out  1  one-cycle pulse: send tx_num.
- tx_num  out  SCORE_W  number to transmit.
- state_o  out  2  0=IDLE, 1=PROC, 2=NORM, 3=SEND.
- frame_done  out  1  one-cycle pulse after the last number is sent.
- overrun  out  1  sticky: rx_available arrived while not IDLE.
- idx_err  out  1  sticky: senone_idx >= N_SENONES, or count mismatch at last_senone.

Behaviour:
- Reset: all outputs 0, state IDLE, buffer contents undefined. Reset mid-frame aborts immediately; nothing completes afterwards.
- Only reset clears the sticky flags.
- IDLE:
  - rx_available && gdp_idle → next cycle: new_vector_available=1, max_clear=1 (both single cycle), score count cleared, enter PROC.
  - rx_available && !gdp_idle → remain IDLE, set overrun.
- PROC:
  - On score_ready with senone_idx < N_SENONES: buf[senone_idx] <= senone_score, count++.
  - On score_ready with senone_idx out of range: no write, set idx_err.
  - score_ready && last_senone: if count+1 != N_SENONES, set idx_err. Enter NORM on the next cycle.
- NORM:
  - Cycle 0 latches best_score into bref. The max unit has registered the last score by then.
  - Then one entry per cycle, i=0..N_SENONES-1: buf[i] <= sat(buf[i] - bref).
  - Subtraction is done at SCORE_W+1 bits and saturated to [-2^(SCORE_W-1), 2^(SCORE_W-1)-1].
  - NORM lasts N_SENONES+1 cycles, then enters SEND.
- SEND, for i=0..N_SENONES-1:
  - SEND_ISSUE: when !tx_busy, tx_num=buf[i] and start_tx=1 for one cycle.
  - SEND_WAIT: wait for tx_busy to be seen high, then low.
  - tx_num holds until the next issue.
  - After the last number falls idle: frame_done=1 for one cycle, return to IDLE.
  - Minimum frame time in SEND: N_SENONES × UART transfer time.
- rx_available in PROC, NORM or SEND: ignored, sets overrun.
- A score_ready outside PROC is ignored.
- state_o changes on the same edge as the internal state.

Optional Feature:
- Macro: SEQ_TIMEOUT_EN.
- Defined:
  - A cycle counter in PROC resets on every score_ready.
  - Reaching TIMEOUT_CYCLES with no score_ready aborts to IDLE, sets sticky output timeout_err and pulses max_clear.
  - timeout_err is a 1-bit output present only in this build; reset value 0.
- Undefined: no counter, no timeout_err port. PROC waits indefinitely for last_senone.

Test Plan:
- Normal frame, N_SENONES=4, scores -10,-3,-7,-20, best_score=-3: → new_vector_available/max_clear pulse once. tx_num sequence -7,0,-4,-17. Four start_tx pulses, then one frame_done; state_o returns to 0.
- Saturation: score -32000 with best_score=+1000: → transmitted value -32768. Any in-range values elsewhere in the frame are exact.
- Out-of-order and bad index, N=4: indices 3,1,0,2 → sent in index order 0..3, no error. Index 7 → idx_err=1, no buffer write.
- Overrun and handshake stall: rx_available during SEND → overrun=1, current frame completes unchanged. Hold tx_busy=1 for 500 cycles → no further start_tx until it drops.
- Reset mid-NORM: assert reset in NORM cycle 2 → all outputs 0 immediately. A subsequent full frame transmits correct values.
- SEQ_TIMEOUT_EN with TIMEOUT_CYCLES=50: two scores, then silence → at cycle 50 timeout_err=1, max_clear pulse, state_o=0. No start_tx issued.
